// File: rtl/m2s_burst_link.sv
// m2s_burst_link
//   Master-to-slave transfer link. Words written by the master are buffered
//   in a DEPTH-entry FIFO and then an output register. From there they go to
//   the slave over a valid/ready handshake, framed into bursts of BURST_LEN
//   beats. In gated mode (BURST_GATE = 1) a burst is held back until the
//   whole burst is buffered.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   data_in        master write data
//   data_en        master write strobe, one word per cycle
//   in_ready       FIFO can accept a write (not full)
//   data_slave_out registered beat offered to the slave
//   slave_valid    data_slave_out holds a beat offered to the slave
//   slave_ready    slave accepts the beat
//   slave_last     offered beat is the final beat of its burst
//   level          words held (FIFO plus output register)
//   overflow       sticky flag: a write was dropped
module m2s_burst_link #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int BURST_LEN  = 8,
   parameter int BURST_GATE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_en,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          data_slave_out,
   output logic                       slave_valid,
   input  logic                       slave_ready,
   output logic                       slave_last,
   output logic [$clog2(DEPTH+1):0]   level,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1) + 1;
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;   // MSB is the wrap bit
   logic              fifo_full, fifo_empty;
   logic              out_occ;
   logic              wr_acc, xfer, out_load;
   logic [BW-1:0]     beat_cnt;
   logic              beat_last;
   logic              release_ok;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready   = !fifo_full;
   assign wr_acc     = data_en && !fifo_full;
   assign xfer       = slave_valid && slave_ready;
   // The output register refills whenever it is free or being drained,
   // regardless of FSM state, so the next beat is ready after a bubble.
   assign out_load   = (!out_occ || xfer) && !fifo_empty;
   assign beat_last  = (beat_cnt == BW'(BURST_LEN - 1));
   assign slave_last = slave_valid && beat_last;
   assign release_ok = (BURST_GATE != 0) ? (level >= LW'(BURST_LEN))
                                         : (level != '0);

   // NOTE: the storage array has no reset; the pointers define which entries
   // are live, so clearing them is enough and keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
   end

   // NOTE: every register here uses <= so all of them see the pre-edge
   // values of each other, exactly like the hardware flops they become.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         out_occ        <= 1'b0;
         data_slave_out <= '0;
         level          <= '0;
         overflow       <= 1'b0;
         beat_cnt       <= '0;
         state          <= IDLE;
      end else begin
         state <= state_nxt;
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (data_en && !wr_acc) overflow <= 1'b1;
         level <= level + LW'(wr_acc) - LW'(xfer);
         if (out_load) begin
            data_slave_out <= mem[rd_ptr[AW-1:0]];
            rd_ptr         <= rd_ptr + 1'b1;
            out_occ        <= 1'b1;
         end else if (xfer) begin
            out_occ <= 1'b0;
         end
         if (xfer) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
   end

   // NOTE: defaults are assigned first so no path leaves an output unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      slave_valid = 1'b0;
      unique case (state)
         IDLE: if (release_ok) state_nxt = SEND;
         SEND: begin
            // An empty output register just stalls; the burst stays open.
            slave_valid = out_occ;
            if (out_occ && slave_ready && beat_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_m2s_burst_link.sv
module tb_m2s_burst_link;

   localparam int LVL_MAX = 17;   // DEPTH + output register

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   // stream-mode instance
   logic [7:0] data_in = '0;
   logic       data_en = 1'b0;
   logic       in_ready;
   logic [7:0] data_slave_out;
   logic       slave_valid;
   logic       slave_ready = 1'b0;
   logic       slave_last;
   logic [5:0] level;
   logic       overflow;
   // gated-mode instance
   logic [7:0] g_data_in = '0;
   logic       g_data_en = 1'b0;
   logic       g_in_ready;
   logic [7:0] g_data_slave_out;
   logic       g_slave_valid;
   logic       g_slave_ready = 1'b0;
   logic       g_slave_last;
   logic [5:0] g_level;
   logic       g_overflow;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_xfer = 0;

   // reference model: contents in order, beats since burst start, sticky flag
   logic [7:0] q[$];
   int         nbeat = 0;
   bit         ovf_m = 1'b0;
   bit         bub   = 1'b0;

   always #5 clk = ~clk;

   m2s_burst_link dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_en(data_en),
      .in_ready(in_ready), .data_slave_out(data_slave_out),
      .slave_valid(slave_valid), .slave_ready(slave_ready),
      .slave_last(slave_last), .level(level), .overflow(overflow)
   );

   m2s_burst_link #(.BURST_GATE(1)) dut_g (
      .clk(clk), .rst(rst), .data_in(g_data_in), .data_en(g_data_en),
      .in_ready(g_in_ready), .data_slave_out(g_data_slave_out),
      .slave_valid(g_slave_valid), .slave_ready(g_slave_ready),
      .slave_last(g_slave_last), .level(g_level), .overflow(g_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_data",     32'(data_slave_out), 32'd0);
      check("rst_valid",    32'(slave_valid), 32'd0);
      check("rst_last",     32'(slave_last), 32'd0);
      check("rst_level",    32'(level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
   endtask

   // Asynchronous reset pulse in mid-cycle; outputs must clear during it.
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      nbeat = 0;
      ovf_m = 1'b0;
      bub   = 1'b0;
   endtask

   // One clock of the stream-mode instance, checked against the model.
   task automatic cyc_a(input bit en, input logic [7:0] d, input bit rdy);
      bit         xf, lst, acc, hold;
      logic [7:0] hd;
      int         start_sz, pending;
      data_en     = en;
      data_in     = d;
      slave_ready = rdy;
      start_sz = q.size();
      xf   = slave_valid && rdy;
      lst  = slave_last;
      hold = slave_valid && !rdy;
      hd   = data_slave_out;
      acc  = en && (start_sz < LVL_MAX);
      if (xf) begin
         check("beat_avail", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            check("beat_data", 32'(data_slave_out), 32'(q[0]));
            void'(q.pop_front());
         end
         check("beat_last", 32'(lst), 32'(nbeat == 7));
         nbeat = (nbeat + 1) % 8;
         n_xfer++;
      end
      pending = q.size();
      if (en && !acc) ovf_m = 1'b1;
      if (acc) q.push_back(d);
      @(posedge clk);
      #1;
      check("level",    32'(level), 32'(q.size()));
      check("in_ready", 32'(in_ready), 32'(q.size() < LVL_MAX));
      check("overflow", 32'(overflow), 32'(ovf_m));
      if (hold) begin
         check("hold_valid", 32'(slave_valid), 32'd1);
         check("hold_data",  32'(data_slave_out), 32'(hd));
      end else if (xf && lst) begin
         check("bubble", 32'(slave_valid), 32'd0);
      end else if (xf && pending > 0) begin
         check("stream_valid", 32'(slave_valid), 32'd1);
      end else if (bub && start_sz > 0) begin
         check("resume_valid", 32'(slave_valid), 32'd1);
      end
      bub = xf && lst;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base;
      // ---------------- reset values ----------------
      #12;
      check_reset_values();
      @(negedge clk);
      rst = 1'b0;

      // ---------------- gated mode: held until fully buffered ----------------
      g_slave_ready = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         g_data_en = 1'b1;
         g_data_in = 8'(i);
         @(posedge clk); #1;
         check("gate_hold", 32'(g_slave_valid), 32'd0);
      end
      g_data_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("gate_hold_idle", 32'(g_slave_valid), 32'd0);
      end
      check("gate_level7", 32'(g_level), 32'd7);
      g_data_en = 1'b1;
      g_data_in = 8'd8;
      @(posedge clk); #1;
      g_data_en = 1'b0;
      check("gate_release_lat", 32'(g_slave_valid), 32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         check("gate_valid", 32'(g_slave_valid), 32'd1);
         check("gate_data",  32'(g_data_slave_out), 32'(i));
         check("gate_last",  32'(g_slave_last), 32'(i == 8));
      end
      @(posedge clk); #1;
      check("gate_done_valid", 32'(g_slave_valid), 32'd0);
      check("gate_done_level", 32'(g_level), 32'd0);

      // ---------------- stream: latency, order, framing, bubbles ----------------
      cyc_a(1'b1, 8'd1, 1'b1);
      check("lat_edge1", 32'(slave_valid), 32'd0);
      cyc_a(1'b1, 8'd2, 1'b1);
      check("lat_edge2_valid", 32'(slave_valid), 32'd1);
      check("lat_edge2_data",  32'(data_slave_out), 32'd1);
      for (int v = 3; v <= 40; v++) cyc_a(1'b1, 8'(v), 1'b1);
      for (int i = 0; i < 20; i++) cyc_a(1'b0, 8'd0, 1'b1);
      check("stream_count", 32'(n_xfer), 32'd40);

      // ---------------- backpressure to full, then overflow ----------------
      do_reset();
      base = n_xfer;
      for (int v = 1; v <= 17; v++) cyc_a(1'b1, 8'(v), 1'b0);
      check("full_level",    32'(level), 32'd17);
      check("full_in_ready", 32'(in_ready), 32'd0);
      cyc_a(1'b1, 8'd99, 1'b0);
      check("drop_overflow", 32'(overflow), 32'd1);
      check("drop_level",    32'(level), 32'd17);
      for (int i = 0; i < 25; i++) cyc_a(1'b0, 8'd0, 1'b1);
      check("drain_count",    32'(n_xfer - base), 32'd17);
      check("drain_overflow", 32'(overflow), 32'd1);

      // ---------------- full FIFO, simultaneous write and transfer ----------------
      do_reset();
      for (int v = 1; v <= 17; v++) cyc_a(1'b1, 8'(v + 32), 1'b0);
      cyc_a(1'b1, 8'd77, 1'b1);
      check("simul_level",    32'(level), 32'd16);
      check("simul_overflow", 32'(overflow), 32'd1);
      for (int i = 0; i < 25; i++) cyc_a(1'b0, 8'd0, 1'b1);

      // ---------------- ready toggled every cycle ----------------
      do_reset();
      for (int v = 1; v <= 12; v++) cyc_a(1'b1, 8'(v + 100), 1'b0);
      for (int i = 0; i < 40; i++) cyc_a(1'b0, 8'd0, 1'(i % 2));
      check("toggle_empty", 32'(level), 32'd0);

      // ---------------- randomized traffic ----------------
      do_reset();
      for (int i = 0; i < 400; i++)
         cyc_a(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 40; i++) cyc_a(1'b0, 8'd0, 1'b1);
      check("rand_drained", 32'(level), 32'd0);

      // ---------------- reset mid-burst with level 5 ----------------
      do_reset();
      for (int v = 1; v <= 5; v++) cyc_a(1'b1, 8'(v + 200), 1'b0);
      check("pre_rst_level", 32'(level), 32'd5);
      check("pre_rst_valid", 32'(slave_valid), 32'd1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc_a(1'b0, 8'd0, 1'b1);
         check("post_rst_quiet", 32'(slave_valid), 32'd0);
      end
      cyc_a(1'b1, 8'hA5, 1'b1);
      cyc_a(1'b0, 8'd0, 1'b1);
      check("post_rst_valid", 32'(slave_valid), 32'd1);
      check("post_rst_data",  32'(data_slave_out), 32'hA5);
      check("post_rst_beat0", 32'(slave_last), 32'd0);
      for (int v = 1; v <= 7; v++) cyc_a(1'b1, 8'(v), 1'b1);
      for (int i = 0; i < 12; i++) cyc_a(1'b0, 8'd0, 1'b1);
      check("post_rst_empty", 32'(level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
